mul_4x4_4x4: RTL and testbench



---
 rtl/mul_4x4_4x4.sv | 102 ++++++++++
 tb/tb_mul_4x4_4x4.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_4x4_4x4.sv
// mul_4x4_4x4: sequential signed fixed-point 4x4 matrix product A x B.
// One k-slice of 16 parallel MACs per enabled cycle, saturating output.
module mul_4x4_4x4 #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            accept_in,
    output logic            accept_out,
    output logic            ready_out,
    input  logic [16*W-1:0] A,
    input  logic [16*W-1:0] B,
    output logic [16*W-1:0] result
);

    localparam int ACC_W = 2*W + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state_q;
    logic [1:0]              k_q;
    logic signed [W-1:0]     a_q [16];
    logic signed [W-1:0]     b_q [16];
    logic signed [ACC_W-1:0] acc_q [16];
    logic signed [ACC_W-1:0] sum_d [16];
    logic [16*W-1:0]         result_q;
    logic [16*W-1:0]         result_d;

    // Floor-shift to output scale, then clamp to the W-bit signed range.
    function automatic logic [W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
        if (&s[ACC_W-1:W-1] || ~|s[ACC_W-1:W-1])
            sat = s[W-1:0];
        else if (s[ACC_W-1])
            sat = {1'b1, {(W-1){1'b0}}};
        else
            sat = {1'b0, {(W-1){1'b1}}};
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic signed [2*W-1:0] prod;
            assign prod = a_q[{2'(i), k_q}] * b_q[{k_q, 2'(j)}];
            assign sum_d[4*i+j] = acc_q[4*i+j]
                + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
            assign result_d[W*(4*i+j) +: W] = sat(sum_d[4*i+j]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            result_q <= '0;
            for (int n = 0; n < 16; n++) begin
                a_q[n]   <= '0;
                b_q[n]   <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        for (int n = 0; n < 16; n++) begin
                            a_q[n]   <= A[W*n +: W];
                            b_q[n]   <= B[W*n +: W];
                            acc_q[n] <= '0;
                        end
                        k_q     <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (enable) begin
                        for (int n = 0; n < 16; n++)
                            acc_q[n] <= sum_d[n];
                        k_q <= k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            result_q <= result_d;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (accept_in)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign accept_out = (state_q == IDLE);
    assign ready_out  = (state_q == DONE);
    assign result     = result_q;

endmodule

// File: tb/tb_mul_4x4_4x4.sv
// Bench for mul_4x4_4x4: directed and random matrices checked via a
// scoreboard against a plain-arithmetic reference product.
module tb_mul_4x4_4x4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         accept_in = 1'b1;
    logic         accept_out;
    logic         ready_out;
    logic [255:0] a_s = '0;
    logic [255:0] b_s = '0;
    logic [255:0] result;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q[$];

    mul_4x4_4x4 dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .accept_in(accept_in),
        .accept_out(accept_out),
        .ready_out(ready_out),
        .A(a_s),
        .B(b_s),
        .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] model(input logic [255:0] a,
                                           input logic [255:0] b);
        logic [255:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'($signed(a[16*(4*i+k) +: 16]))
                       * longint'($signed(b[16*(4*k+j) +: 16]));
                s = s >>> 8;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                r[16*(4*i+j) +: 16] = s[15:0];
            end
        return r;
    endfunction

    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] r;
        for (int n = 0; n < 16; n++) r[16*n +: 16] = v;
        return r;
    endfunction

    function automatic logic [255:0] diag(input logic [15:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[16*(5*i) +: 16] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // Monitor: each new result presentation pops one expected product.
    initial begin
        logic rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_out && !rdy_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected act=%h req=none", result);
                end else begin
                    check("sb_result", result, exp_q.pop_front());
                end
            end
            rdy_prev = ready_out;
        end
    end

    task automatic wait_idle();
        int n;
        for (n = 0; n < 30 && !accept_out; n++) @(posedge clk) #1;
        if (!accept_out) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout act=0 req=1");
        end
    endtask

    task automatic run_one(input logic [255:0] a, input logic [255:0] b,
                           input bit stall, input bit hold);
        int n;
        logic [255:0] snap;
        wait_idle();
        a_s = a;
        b_s = b;
        enable = 1'b1;
        accept_in = hold ? 1'b0 : 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk) #1;
        a_s = ~a;
        b_s = ~b;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk) #1;
            if (stall && n == 2) enable = 1'b0;
            if (stall && n == 5) enable = 1'b1;
            if (ready_out) break;
        end
        enable = 1'b0;
        checks++;
        if (n != (stall ? 7 : 4)) begin
            errors++;
            $display("FAIL latency act=%0d req=%0d", n, stall ? 7 : 4);
        end
        if (hold) begin
            snap = result;
            for (int c = 0; c < 10; c++) @(posedge clk) #1;
            check("hold_ready", 256'(ready_out), 256'(1));
            check("hold_result", result, snap);
            accept_in = 1'b1;
            @(posedge clk) #1;
            check("release_ready", 256'(ready_out), 256'(0));
            check("release_accept", 256'(accept_out), 256'(1));
        end
    endtask

    initial begin
        logic [255:0] ra, rb;
        #2;
        check("rst_accept", 256'(accept_out), 256'(1));
        check("rst_ready", 256'(ready_out), 256'(0));
        check("rst_result", result, '0);
        #20 reset_n = 1'b1;
        @(posedge clk) #1;

        for (int n = 0; n < 16; n++) rb[16*n +: 16] = 16'(16*n);
        run_one(diag(16'h0100), rb, 0, 0);
        check("identity", result, rb);

        run_one(diag(16'hFF00), fill(16'h0200), 0, 0);
        check("neg_one", result, fill(16'hFE00));
        run_one(fill(16'h0080), fill(16'h0100), 0, 0);
        check("half", result, fill(16'h0200));
        run_one(fill(16'h7FFF), fill(16'h7FFF), 0, 0);
        check("sat_pos", result, fill(16'h7FFF));
        run_one(fill(16'h7FFF), fill(16'h8000), 0, 0);
        check("sat_neg", result, fill(16'h8000));

        ra = '0; ra[15:0] = 16'h0001;
        rb = '0; rb[15:0] = 16'h0001;
        run_one(ra, rb, 0, 0);
        check("trunc_pos", result, '0);
        ra[15:0] = 16'hFFFF;
        run_one(ra, rb, 0, 0);
        check("trunc_neg", 256'(result[15:0]), 256'(16'hFFFF));

        run_one(fill(16'h0100), diag(16'h0300), 0, 1);
        run_one(diag(16'h0180), fill(16'hFFC0), 1, 0);

        wait_idle();
        a_s = fill(16'h0100);
        b_s = fill(16'h0100);
        enable = 1'b1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        #2 reset_n = 1'b0;
        #1;
        check("abort_accept", 256'(accept_out), 256'(1));
        check("abort_ready", 256'(ready_out), 256'(0));
        check("abort_result", result, '0);
        enable = 1'b0;
        @(posedge clk) #1;
        reset_n = 1'b1;
        @(posedge clk) #1;
        run_one(fill(16'h0100), fill(16'h0100), 0, 0);
        check("post_reset", result, fill(16'h0400));

        for (int t = 0; t < 40; t++) begin
            for (int n = 0; n < 16; n++) begin
                if (t % 2 == 0) begin
                    ra[16*n +: 16] = 16'($urandom);
                    rb[16*n +: 16] = 16'($urandom);
                end else begin
                    ra[16*n +: 16] = 16'($urandom_range(0, 1024) - 512);
                    rb[16*n +: 16] = 16'($urandom_range(0, 1024) - 512);
                end
            end
            run_one(ra, rb, 0, 0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
